// File: rtl/cpu_mc_pkg.sv
// rtl/cpu_mc_pkg.sv - shared types for the cpu_mc core: FSM states, opcodes, status bit positions
package cpu_mc_pkg;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_OPER,
    ST_OPER_HI,
    ST_EXEC
  } state_t;

  localparam logic [7:0] OP_LDA = 8'hA9;
  localparam logic [7:0] OP_LDX = 8'hA2;
  localparam logic [7:0] OP_LDY = 8'hA0;
  localparam logic [7:0] OP_ADC = 8'h69;
  localparam logic [7:0] OP_SBC = 8'hE9;
  localparam logic [7:0] OP_INX = 8'hE8;
  localparam logic [7:0] OP_INY = 8'hC8;
  localparam logic [7:0] OP_DEX = 8'hCA;
  localparam logic [7:0] OP_DEY = 8'h88;
  localparam logic [7:0] OP_CLC = 8'h18;
  localparam logic [7:0] OP_SEC = 8'h38;
  localparam logic [7:0] OP_NOP = 8'hEA;
  localparam logic [7:0] OP_JMP = 8'h4C;
  localparam logic [7:0] OP_BEQ = 8'hF0;
  localparam logic [7:0] OP_BNE = 8'hD0;

  localparam int P_N = 7;
  localparam int P_V = 6;
  localparam int P_U = 5;
  localparam int P_Z = 1;
  localparam int P_C = 0;

  function automatic logic needs_operand(input logic [7:0] op);
    case (op)
      OP_LDA, OP_LDX, OP_LDY, OP_ADC, OP_SBC, OP_JMP, OP_BEQ, OP_BNE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_supported(input logic [7:0] op);
    case (op)
      OP_INX, OP_INY, OP_DEX, OP_DEY, OP_CLC, OP_SEC, OP_NOP: return 1'b1;
      default: return needs_operand(op);
    endcase
  endfunction

endpackage

// File: rtl/cpu_mc_if.sv
// rtl/cpu_mc_if.sv - memory read bus between the cpu_mc core (master) and program memory (slave)
interface cpu_mc_if #(
  parameter int ADDR_W = 16
);
  logic              ready;
  logic [7:0]        data;
  logic [ADDR_W-1:0] addr;
  logic              sync;

  modport master (input ready, input data, output addr, output sync);
  modport slave  (output ready, output data, input addr, input sync);
endinterface

// File: rtl/cpu_mc_alu.sv
// rtl/cpu_mc_alu.sv - 8-bit adder with carry/overflow and optional BCD correction
module cpu_mc_alu (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  input  logic       decimal_mode,
  output logic [7:0] result,
  output logic       c_out,
  output logic       v_out
);

  logic [8:0] bin_sum;
  logic [5:0] lo;
  logic [5:0] hi;

  always_comb begin
    bin_sum = {1'b0, a} + {1'b0, b} + {8'b0, c_in};
    lo = {2'b0, a[3:0]} + {2'b0, b[3:0]} + {5'b0, c_in};
    if (lo > 6'd9) lo = lo + 6'd6;
    hi = {2'b0, a[7:4]} + {2'b0, b[7:4]} + {5'b0, (lo > 6'd15)};
    if (hi > 6'd9) hi = hi + 6'd6;
    // Overflow is taken from the binary sum in both modes.
    v_out = (a[7] == b[7]) && (bin_sum[7] != a[7]);
    if (decimal_mode) begin
      result = {hi[3:0], lo[3:0]};
      c_out  = (hi > 6'd15);
    end else begin
      result = bin_sum[7:0];
      c_out  = bin_sum[8];
    end
  end

endmodule

// File: rtl/cpu_mc.sv
// rtl/cpu_mc.sv - multi-cycle 8-bit core: fetch/operand/exec FSM over a ready-stallable read bus
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic       clk,
  input  logic       rst,
  cpu_mc_if.master   bus,
  output logic [7:0] acc_out,
  output logic [7:0] x_out,
  output logic [7:0] y_out,
  output logic [7:0] status_out,
  output logic       illegal
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        opcode;
  logic [7:0]        oper_lo;
  logic [7:0]        acc, x_reg, y_reg;
  logic              flag_n, flag_v, flag_z, flag_c;

  logic [ADDR_W-1:0] pc_inc;
  logic [15:0]       br_off16;
  logic [15:0]       jmp16;
  logic [ADDR_W-1:0] br_target;
  logic [7:0]        alu_b, alu_res;
  logic              alu_c, alu_v;
  logic [7:0]        x_inc, x_dec, y_inc, y_dec;

  assign pc_inc    = pc + 1'b1;
  assign br_off16  = {{8{bus.data[7]}}, bus.data};
  assign br_target = pc_inc + br_off16[ADDR_W-1:0];
  assign jmp16     = {bus.data, oper_lo};
  assign x_inc     = x_reg + 8'd1;
  assign x_dec     = x_reg - 8'd1;
  assign y_inc     = y_reg + 8'd1;
  assign y_dec     = y_reg - 8'd1;

  // SBC reuses the adder by feeding it the inverted operand.
  assign alu_b = (opcode == OP_SBC) ? ~bus.data : bus.data;

  cpu_mc_alu u_alu (
    .a            (acc),
    .b            (alu_b),
    .c_in         (flag_c),
    .decimal_mode (1'b0),
    .result       (alu_res),
    .c_out        (alu_c),
    .v_out        (alu_v)
  );

  assign bus.addr = pc;
  assign bus.sync = (state == ST_FETCH);
  assign acc_out  = acc;
  assign x_out    = x_reg;
  assign y_out    = y_reg;

  always_comb begin
    status_out      = 8'h00;
    status_out[P_N] = flag_n;
    status_out[P_V] = flag_v;
    status_out[P_U] = 1'b1;
    status_out[P_Z] = flag_z;
    status_out[P_C] = flag_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      pc      <= RESET_PC;
      opcode  <= OP_NOP;
      oper_lo <= 8'h00;
      acc     <= 8'h00;
      x_reg   <= 8'h00;
      y_reg   <= 8'h00;
      flag_n  <= 1'b0;
      flag_v  <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      illegal <= 1'b0;
    end else if (bus.ready) begin
      case (state)
        ST_FETCH: begin
          opcode <= bus.data;
          pc     <= pc_inc;
          state  <= needs_operand(bus.data) ? ST_OPER : ST_EXEC;
          if (!is_supported(bus.data)) illegal <= 1'b1;
        end
        ST_OPER: begin
          pc    <= pc_inc;
          state <= ST_FETCH;
          case (opcode)
            OP_LDA: begin acc   <= bus.data; flag_n <= bus.data[7]; flag_z <= (bus.data == 8'h00); end
            OP_LDX: begin x_reg <= bus.data; flag_n <= bus.data[7]; flag_z <= (bus.data == 8'h00); end
            OP_LDY: begin y_reg <= bus.data; flag_n <= bus.data[7]; flag_z <= (bus.data == 8'h00); end
            OP_ADC, OP_SBC: begin
              acc    <= alu_res;
              flag_c <= alu_c;
              flag_v <= alu_v;
              flag_n <= alu_res[7];
              flag_z <= (alu_res == 8'h00);
            end
            OP_JMP: begin
              oper_lo <= bus.data;
              state   <= ST_OPER_HI;
            end
            OP_BEQ: if (flag_z)  pc <= br_target;
            OP_BNE: if (!flag_z) pc <= br_target;
            default: ;
          endcase
        end
        ST_OPER_HI: begin
          pc    <= jmp16[ADDR_W-1:0];
          state <= ST_FETCH;
        end
        ST_EXEC: begin
          state <= ST_FETCH;
          case (opcode)
            OP_INX: begin x_reg <= x_inc; flag_n <= x_inc[7]; flag_z <= (x_inc == 8'h00); end
            OP_INY: begin y_reg <= y_inc; flag_n <= y_inc[7]; flag_z <= (y_inc == 8'h00); end
            OP_DEX: begin x_reg <= x_dec; flag_n <= x_dec[7]; flag_z <= (x_dec == 8'h00); end
            OP_DEY: begin y_reg <= y_dec; flag_n <= y_dec[7]; flag_z <= (y_dec == 8'h00); end
            OP_CLC: flag_c <= 1'b0;
            OP_SEC: flag_c <= 1'b1;
            default: ;
          endcase
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mc.sv
// tb/tb_cpu_mc.sv - scoreboard bench for cpu_mc: instruction-level model vs. DUT at every opcode fetch
module tb_cpu_mc;
  import cpu_mc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready_drv = 1'b1;
  always #5 clk = ~clk;

  cpu_mc_if #(.ADDR_W(16)) bus ();
  cpu_mc_if #(.ADDR_W(8))  bus8 ();

  logic [7:0] mem  [0:65535];
  logic [7:0] mem8 [0:255];
  logic [7:0] acc, xr, yr, pr;
  logic       ill;
  logic [7:0] acc8, xr8, yr8, pr8;
  logic       ill8;

  assign bus.ready  = ready_drv;
  assign bus.data   = mem[bus.addr];
  assign bus8.ready = 1'b1;
  assign bus8.data  = mem8[bus8.addr];

  cpu_mc #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .acc_out(acc), .x_out(xr), .y_out(yr), .status_out(pr), .illegal(ill)
  );

  cpu_mc #(.ADDR_W(8), .RESET_PC(8'h00)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8),
    .acc_out(acc8), .x_out(xr8), .y_out(yr8), .status_out(pr8), .illegal(ill8)
  );

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  a, x, y, p;
    logic        il;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int consumed = 0;
  int target = 0;
  int act_cyc = 0;
  logic [15:0] last_fetch_pc = 16'h0000;

  // Architectural model: one call executes one whole instruction.
  logic [15:0] m_pc;
  logic [7:0]  m_a, m_x, m_y;
  logic        m_n, m_v, m_z, m_c, m_ill;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_exp(input int cyc);
    exp_t n;
    n.pc = m_pc; n.a = m_a; n.x = m_x; n.y = m_y;
    n.p = {m_n, m_v, 1'b1, 3'b000, m_z, m_c};
    n.il = m_ill; n.cyc = cyc;
    sbq.push_back(n);
    target++;
  endtask

  task automatic set_nz(input logic [7:0] r);
    m_n = r[7];
    m_z = (r == 8'h00);
  endtask

  task automatic do_add(input logic [7:0] m);
    int sum, sa, sm, ss;
    sum = int'(m_a) + int'(m) + int'(m_c);
    sa = m_a[7] ? int'(m_a) - 256 : int'(m_a);
    sm = m[7] ? int'(m) - 256 : int'(m);
    ss = sa + sm + int'(m_c);
    m_c = (sum > 255);
    m_v = (ss > 127) || (ss < -128);
    m_a = sum[7:0];
    set_nz(m_a);
  endtask

  task automatic model_step();
    logic [7:0] op, o1, o2;
    logic [15:0] p1, p2;
    int t, cyc;
    p1 = m_pc + 16'd1;
    p2 = m_pc + 16'd2;
    op = mem[m_pc]; o1 = mem[p1]; o2 = mem[p2];
    cyc = 2;
    t = int'(m_pc) + 2;
    case (op)
      8'hA9: begin m_a = o1; set_nz(o1); end
      8'hA2: begin m_x = o1; set_nz(o1); end
      8'hA0: begin m_y = o1; set_nz(o1); end
      8'h69: do_add(o1);
      8'hE9: do_add(~o1);
      8'hE8: begin m_x = m_x + 8'd1; set_nz(m_x); t = t - 1; end
      8'hC8: begin m_y = m_y + 8'd1; set_nz(m_y); t = t - 1; end
      8'hCA: begin m_x = m_x - 8'd1; set_nz(m_x); t = t - 1; end
      8'h88: begin m_y = m_y - 8'd1; set_nz(m_y); t = t - 1; end
      8'h18: begin m_c = 1'b0; t = t - 1; end
      8'h38: begin m_c = 1'b1; t = t - 1; end
      8'hEA: t = t - 1;
      8'h4C: begin t = {16'h0, o2, o1}; cyc = 3; end
      8'hF0, 8'hD0: if ((op == 8'hF0) == m_z) t = t + (o1[7] ? int'(o1) - 256 : int'(o1));
      default: begin m_ill = 1'b1; t = t - 1; end
    endcase
    m_pc = t[15:0];
    push_exp(cyc);
  endtask

  task automatic model_reset();
    sbq.delete();
    target = 0;
    consumed = 0;
    m_pc = 16'h0000; m_a = 8'h00; m_x = 8'h00; m_y = 8'h00;
    m_n = 1'b0; m_v = 1'b0; m_z = 1'b0; m_c = 1'b0; m_ill = 1'b0;
    push_exp(0);
  endtask

  // Monitor: every accepted opcode fetch is compared with the next scoreboard entry.
  always @(negedge clk) begin
    if (rst) begin
      act_cyc = 0;
    end else if (bus.ready) begin
      if (bus.sync) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_underflow: got fetch at %0h expected no fetch", bus.addr);
        end else begin
          e = sbq.pop_front();
          check("fetch_pc", bus.addr, e.pc);
          check("acc", acc, e.a);
          check("x", xr, e.x);
          check("y", yr, e.y);
          check("status", pr, e.p);
          check("illegal", ill, e.il);
          if (e.cyc != 0) check("cycles", act_cyc, e.cyc);
        end
        last_fetch_pc = bus.addr;
        consumed++;
        act_cyc = 1;
      end else begin
        act_cyc++;
      end
    end
  end

  task automatic do_reset();
    #1;
    rst = 1'b1;
    ready_drv = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic run_instrs(input int n, input bit rand_ready);
    int budget;
    for (int i = 0; i < n; i++) model_step();
    budget = 0;
    while (consumed < target && budget < n * 16 + 20) begin
      @(posedge clk);
      #1;
      ready_drv = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      budget++;
    end
    if (consumed < target) begin
      total++; bad++;
      $display("FAIL timeout: got %0d fetches expected %0d", consumed, target);
    end
    ready_drv = 1'b1;
  endtask

  task automatic fill_all(input logic [7:0] v);
    for (int i = 0; i < 65536; i++) mem[i] = v;
    for (int i = 0; i < 256; i++) mem8[i] = v;
  endtask

  task automatic fill_random();
    logic [7:0] ops [15];
    ops = '{8'hA9, 8'hA2, 8'hA0, 8'h69, 8'hE9, 8'hE8, 8'hC8, 8'hCA,
            8'h88, 8'h18, 8'h38, 8'hEA, 8'h4C, 8'hF0, 8'hD0};
    for (int i = 0; i < 65536; i++)
      mem[i] = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 14)] : 8'($urandom);
  endtask

  initial begin
    // Reset state, then A9 7F 69 01: signed overflow into N.
    fill_all(8'hEA);
    mem[0] = 8'hA9; mem[1] = 8'h7F; mem[2] = 8'h69; mem[3] = 8'h01;
    do_reset();
    @(negedge clk);
    check("rst_addr", bus.addr, 16'h0000);
    check("rst_sync", bus.sync, 1'b1);
    check("rst_regs", {acc, xr, yr, pr, ill}, {8'h00, 8'h00, 8'h00, 8'h20, 1'b0});
    run_instrs(2, 1'b0);
    check("adc_ovf_acc", acc, 8'h80);
    check("adc_ovf_status", pr, 8'hE0);

    // X wrap FF -> 00 -> FF.
    fill_all(8'hEA);
    mem[0] = 8'hA2; mem[1] = 8'hFF; mem[2] = 8'hE8; mem[3] = 8'hCA;
    do_reset();
    run_instrs(2, 1'b0);
    check("inx_wrap_x", xr, 8'h00);
    check("inx_wrap_status", pr, 8'h22);
    run_instrs(1, 1'b0);
    check("dex_wrap_x", xr, 8'hFF);
    check("dex_wrap_status", pr, 8'hA0);

    // JMP 1234 on both address widths.
    fill_all(8'hEA);
    mem[0] = 8'h4C; mem[1] = 8'h34; mem[2] = 8'h12;
    mem8[0] = 8'h4C; mem8[1] = 8'h34; mem8[2] = 8'h12;
    do_reset();
    model_step();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("jmp16_addr", bus.addr, 16'h1234);
    check("jmp16_sync", bus.sync, 1'b1);
    check("jmp8_addr", bus8.addr, 8'h34);
    check("jmp8_sync", bus8.sync, 1'b1);
    check("jmp8_regs", {acc8, xr8, yr8, pr8, ill8}, {8'h00, 8'h00, 8'h00, 8'h20, 1'b0});

    // Reset during OPER_HI aborts the jump.
    do_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("operhi_addr", bus.addr, 16'h0002);
    check("operhi_sync", bus.sync, 1'b0);
    do_reset();
    @(negedge clk);
    check("abort_addr", bus.addr, 16'h0000);
    check("abort_sync", bus.sync, 1'b1);

    // Backward BEQ taken, then BNE not taken.
    fill_all(8'hEA);
    mem[0] = 8'h4C; mem[1] = 8'h10; mem[2] = 8'h00;
    mem[16'h10] = 8'hA9; mem[16'h11] = 8'h00; mem[16'h12] = 8'hF0; mem[16'h13] = 8'hFC;
    do_reset();
    run_instrs(3, 1'b0);
    check("beq_taken_pc", last_fetch_pc, 16'h0010);
    mem[16'h12] = 8'hD0;
    do_reset();
    run_instrs(3, 1'b0);
    check("bne_fall_pc", last_fetch_pc, 16'h0014);

    // Wait states in OPER of A9 55.
    fill_all(8'hEA);
    mem[0] = 8'hA9; mem[1] = 8'h55;
    do_reset();
    model_step();
    @(posedge clk);
    #1 ready_drv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_addr", bus.addr, 16'h0001);
      check("stall_sync", bus.sync, 1'b0);
      check("stall_acc", acc, 8'h00);
      @(posedge clk);
    end
    #1 ready_drv = 1'b1;
    @(negedge clk);
    check("stall_hold_acc", acc, 8'h00);
    @(negedge clk);
    check("stall_done_acc", acc, 8'h55);

    // Unsupported opcode is a sticky 2-cycle NOP.
    fill_all(8'hEA);
    mem[0] = 8'h02; mem[1] = 8'hA9; mem[2] = 8'h80;
    do_reset();
    run_instrs(3, 1'b0);
    check("illegal_set", ill, 1'b1);
    check("illegal_acc", acc, 8'h80);
    do_reset();
    @(negedge clk);
    check("illegal_clr", ill, 1'b0);

    // PC wrap at the top of the address space.
    mem[0] = 8'h4C; mem[1] = 8'hFE; mem[2] = 8'hFF;
    mem[16'hFFFE] = 8'hA9; mem[16'hFFFF] = 8'h33;
    do_reset();
    run_instrs(2, 1'b0);
    check("wrap_pc", last_fetch_pc, 16'h0000);
    check("wrap_acc", acc, 8'h33);

    // Random programs with random wait states.
    for (int r = 0; r < 3; r++) begin
      fill_random();
      do_reset();
      run_instrs(400, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
